// File: rtl/apb2uart.sv
// apb2uart: APB slave that serialises host register accesses into 9-bit
// UART command frames for a remote register bridge. It also collects read
// data from that bridge's read-ack frames.
// Byte format: bit0=0 is a header {0, dst[3:0], op[2:0], 0}; bit0=1 is data in [8:1].
module apb2uart #(
    parameter int TIMEOUT_CYCLES = 1250000
) (
    input  logic        clk,
    input  logic        rst_n,
    // APB slave
    input  logic        psel,
    input  logic        penable,
    input  logic [19:0] paddr,
    input  logic        pwrite,
    input  logic [31:0] pwdata,
    input  logic [3:0]  pstrb,
    input  logic [2:0]  pprot,
    output logic        pready,
    output logic [31:0] prdata,
    output logic        pslverr,
    // request stream towards UART tx
    output logic        m_axis_tvalid,
    output logic [8:0]  m_axis_tdata,
    output logic        m_axis_tlast,
    output logic        m_axis_tuser,
    input  logic        m_axis_tready,
    // response stream from UART rx
    input  logic        s_axis_tvalid,
    input  logic [8:0]  s_axis_tdata,
    input  logic        s_axis_tlast,
    input  logic        s_axis_tuser,
    output logic        s_axis_tready,
    // status
    output logic        busy,
    output logic [31:0] wr_count,
    output logic [31:0] rd_count,
    output logic [31:0] timeout_count
);

    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] OP_WRITE    = 3'd1;
    localparam logic [2:0] OP_READ     = 3'd2;
    localparam logic [2:0] OP_READ_ACK = 3'd3;

    typedef enum logic [3:0] {
        IDLE,
        TX_HDR,
        TX_ADDR0,
        TX_ADDR1,
        TX_WD0,
        TX_WD1,
        TX_WD2,
        TX_WD3,
        WAIT_ACK,
        RX0,
        RX1,
        RX2,
        RX3,
        DONE
    } state_t;

    state_t         state_q, state_d;
    logic [19:0]    paddr_q, paddr_d;
    logic           pwrite_q, pwrite_d;
    logic [31:0]    pwdata_q, pwdata_d;
    logic           tvalid_q, tvalid_d;
    logic [8:0]     tdata_q, tdata_d;
    logic           tlast_q, tlast_d;
    logic           pready_q, pready_d;
    logic           pslverr_q, pslverr_d;
    logic [31:0]    prdata_q, prdata_d;
    logic           busy_q, busy_d;
    logic [TW-1:0]  tmo_q, tmo_d;
    logic [31:0]    wr_count_q, wr_count_d;
    logic [31:0]    rd_count_q, rd_count_d;
    logic [31:0]    timeout_count_q, timeout_count_d;

    logic mfire;
    logic rx_data;
    logic rx_hdr;
    logic ack_hdr;
    logic tmo_hit;

    // Inputs that carry no meaning for this bridge (full-word writes only,
    // no protection checks, rx framing is implied by the header/data bit).
    logic unused_inputs;
    assign unused_inputs = ^{pstrb, pprot, s_axis_tlast, s_axis_tuser};

    assign mfire   = tvalid_q && m_axis_tready;
    assign rx_data = s_axis_tvalid && s_axis_tdata[0];
    assign rx_hdr  = s_axis_tvalid && !s_axis_tdata[0];
    assign ack_hdr = rx_hdr && (s_axis_tdata[3:1] == OP_READ_ACK)
                     && (s_axis_tdata[7:4] == paddr_q[19:16]);
    assign tmo_hit = (tmo_q == TMO_MAX);

    // Next-state, stream byte sequencing, response capture and counters.
    always_comb begin
        state_d         = state_q;
        paddr_d         = paddr_q;
        pwrite_d        = pwrite_q;
        pwdata_d        = pwdata_q;
        tvalid_d        = tvalid_q;
        tdata_d         = tdata_q;
        tlast_d         = tlast_q;
        pready_d        = 1'b0;
        pslverr_d       = 1'b0;
        prdata_d        = prdata_q;
        tmo_d           = tmo_q;
        wr_count_d      = wr_count_q;
        rd_count_d      = rd_count_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            IDLE: begin
                // Only a setup phase starts a transfer; late rx bytes are dropped.
                if (psel && !penable) begin
                    paddr_d  = paddr;
                    pwrite_d = pwrite;
                    pwdata_d = pwdata;
                    state_d  = TX_HDR;
                    tvalid_d = 1'b1;
                    tlast_d  = 1'b0;
                    tdata_d  = {1'b0, paddr[19:16], (pwrite ? OP_WRITE : OP_READ), 1'b0};
                end
            end
            TX_HDR: begin
                if (mfire) begin
                    state_d = TX_ADDR0;
                    tdata_d = {paddr_q[7:0], 1'b1};
                end
            end
            TX_ADDR0: begin
                if (mfire) begin
                    state_d = TX_ADDR1;
                    tdata_d = {paddr_q[15:8], 1'b1};
                    tlast_d = !pwrite_q;
                end
            end
            TX_ADDR1: begin
                if (mfire) begin
                    if (pwrite_q) begin
                        state_d = TX_WD0;
                        tdata_d = {pwdata_q[7:0], 1'b1};
                    end else begin
                        // Request fully sent: arm the ack timeout from zero.
                        state_d  = WAIT_ACK;
                        tvalid_d = 1'b0;
                        tlast_d  = 1'b0;
                        tmo_d    = '0;
                    end
                end
            end
            TX_WD0: begin
                if (mfire) begin
                    state_d = TX_WD1;
                    tdata_d = {pwdata_q[15:8], 1'b1};
                end
            end
            TX_WD1: begin
                if (mfire) begin
                    state_d = TX_WD2;
                    tdata_d = {pwdata_q[23:16], 1'b1};
                end
            end
            TX_WD2: begin
                if (mfire) begin
                    state_d = TX_WD3;
                    tdata_d = {pwdata_q[31:24], 1'b1};
                    tlast_d = 1'b1;
                end
            end
            TX_WD3: begin
                if (mfire) begin
                    state_d    = DONE;
                    tvalid_d   = 1'b0;
                    tlast_d    = 1'b0;
                    pready_d   = 1'b1;
                    wr_count_d = wr_count_q + 32'd1;
                end
            end
            WAIT_ACK, RX0, RX1, RX2, RX3: begin
                tmo_d = tmo_hit ? tmo_q : tmo_q + TW'(1);
                if (tmo_hit) begin
                    // Timeout wins over any byte arriving in the same cycle.
                    state_d         = DONE;
                    pready_d        = 1'b1;
                    pslverr_d       = 1'b1;
                    prdata_d        = '0;
                    timeout_count_d = timeout_count_q + 32'd1;
                end else if (state_q == WAIT_ACK) begin
                    if (ack_hdr) begin
                        state_d = RX0;
                    end
                end else if (rx_data) begin
                    prdata_d = {s_axis_tdata[8:1], prdata_q[31:8]};
                    case (state_q)
                        RX0:     state_d = RX1;
                        RX1:     state_d = RX2;
                        RX2:     state_d = RX3;
                        default: begin
                            state_d    = DONE;
                            pready_d   = 1'b1;
                            rd_count_d = rd_count_q + 32'd1;
                        end
                    endcase
                end else if (rx_hdr) begin
                    // A fresh ack restarts the payload; anything else resyncs.
                    state_d = ack_hdr ? RX0 : WAIT_ACK;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d  = IDLE;
                tvalid_d = 1'b0;
                tlast_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops any frame in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            paddr_q         <= '0;
            pwrite_q        <= 1'b0;
            pwdata_q        <= '0;
            tvalid_q        <= 1'b0;
            tdata_q         <= '0;
            tlast_q         <= 1'b0;
            pready_q        <= 1'b0;
            pslverr_q       <= 1'b0;
            prdata_q        <= '0;
            busy_q          <= 1'b0;
            tmo_q           <= '0;
            wr_count_q      <= '0;
            rd_count_q      <= '0;
            timeout_count_q <= '0;
        end else begin
            state_q         <= state_d;
            paddr_q         <= paddr_d;
            pwrite_q        <= pwrite_d;
            pwdata_q        <= pwdata_d;
            tvalid_q        <= tvalid_d;
            tdata_q         <= tdata_d;
            tlast_q         <= tlast_d;
            pready_q        <= pready_d;
            pslverr_q       <= pslverr_d;
            prdata_q        <= prdata_d;
            busy_q          <= busy_d;
            tmo_q           <= tmo_d;
            wr_count_q      <= wr_count_d;
            rd_count_q      <= rd_count_d;
            timeout_count_q <= timeout_count_d;
        end
    end

    assign pready        = pready_q;
    assign pslverr       = pslverr_q;
    assign prdata        = prdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tuser  = 1'b0;
    assign s_axis_tready = 1'b1;
    assign busy          = busy_q;
    assign wr_count      = wr_count_q;
    assign rd_count      = rd_count_q;
    assign timeout_count = timeout_count_q;

endmodule
